// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - LCD slot scanner, CPU clock stepper/divider and memory watch registers
// Optional: DISPLAY_STEP_COUNT_EN adds a saturating cpu_clk step counter shown as "STEPS".
module display_scan_ctrl #(
  parameter int          DATA_W    = 32,
  parameter int          RF_NUM    = 32,
  parameter int          MEM_WATCH = 2,
  parameter logic [15:0] DEBOUNCE  = 16'd50000,
  parameter logic [15:0] RUN_DIV   = 16'd5000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_clk,
  input  logic              run_mode,
  output logic              cpu_clk,
  input  logic [DATA_W-1:0] cpu_pc,
  input  logic [DATA_W-1:0] cpu_inst,
  output logic [4:0]        rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic [DATA_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [5:0]        display_number,
  input  logic              input_valid,
  input  logic [DATA_W-1:0] input_value,
  output logic              display_valid,
  output logic [39:0]       display_name,
  output logic [DATA_W-1:0] display_value
);

  localparam int BASE_RF = 3 + 2 * MEM_WATCH;
`ifdef DISPLAY_STEP_COUNT_EN
  localparam int STEP_SLOT = BASE_RF + RF_NUM;
`endif

  typedef enum logic [2:0] {K_NONE, K_PC, K_INST, K_MADR, K_MDAT, K_RF, K_STEPS} slot_kind_e;

  function automatic slot_kind_e kind_of(input logic [5:0] s);
    int si;
    si = int'(s);
    if (si > 44) return K_NONE;
    if (si == 1) return K_PC;
    if (si == 2) return K_INST;
    if (si >= 3 && si < BASE_RF) return (((si - 3) % 2) == 0) ? K_MADR : K_MDAT;
    if (si >= BASE_RF && si < BASE_RF + RF_NUM) return K_RF;
`ifdef DISPLAY_STEP_COUNT_EN
    if (si == STEP_SLOT) return K_STEPS;
`endif
    return K_NONE;
  endfunction

  function automatic logic [1:0] watch_of(input logic [5:0] s);
    int si;
    si = int'(s);
    if (si >= 3 && si < BASE_RF) return 2'((si - 3) / 2);
    return 2'd0;
  endfunction

  function automatic logic [4:0] reg_of(input logic [5:0] s);
    return 5'(int'(s) - BASE_RF);
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] d);
    return (d < 4'd10) ? (8'h30 + {4'h0, d}) : (8'h41 + {4'h0, d} - 8'd10);
  endfunction

  logic [5:0]        r_slot;
  logic [4:0]        r_rf_addr;
  logic [DATA_W-1:0] r_watch [MEM_WATCH];
  logic              r_valid;
  logic [39:0]       r_name;
  logic [DATA_W-1:0] r_value;
  logic [31:0]       r_steps;

  slot_kind_e        w_s1_kind;
  slot_kind_e        w_in_kind;
  logic [1:0]        w_s1_k;
  logic [1:0]        w_wr_k;
  logic [4:0]        w_s1_idx;
  logic [4:0]        w_in_idx;
  logic [DATA_W-1:0] w_watch_k;

  assign w_s1_kind = kind_of(r_slot);
  assign w_s1_k    = watch_of(r_slot);
  assign w_s1_idx  = reg_of(r_slot);
  assign w_in_kind = kind_of(display_number);
  assign w_in_idx  = reg_of(display_number);
  assign w_wr_k    = (w_s1_kind == K_MADR || w_s1_kind == K_MDAT) ? w_s1_k : 2'd0;

  always_comb begin
    w_watch_k = r_watch[0];
    for (int i = 0; i < MEM_WATCH; i++) begin
      if (w_s1_k == 2'(i)) w_watch_k = r_watch[i];
    end
  end

  // Memory port parks on watch 0 unless an MDAT slot needs its own address.
  assign mem_addr = (w_s1_kind == K_MDAT) ? w_watch_k : r_watch[0];
  assign rf_addr  = r_rf_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_slot    <= '0;
      r_rf_addr <= '0;
      r_valid   <= 1'b0;
      r_name    <= '0;
      r_value   <= '0;
      for (int i = 0; i < MEM_WATCH; i++) r_watch[i] <= '0;
    end else begin
      r_slot <= display_number;
      if (w_in_kind == K_RF) r_rf_addr <= w_in_idx;
      for (int i = 0; i < MEM_WATCH; i++) begin
        if (input_valid && w_wr_k == 2'(i)) r_watch[i] <= input_value;
      end
      r_valid <= 1'b1;
      case (w_s1_kind)
        K_PC: begin
          r_name  <= "   PC";
          r_value <= cpu_pc;
        end
        K_INST: begin
          r_name  <= " INST";
          r_value <= cpu_inst;
        end
        K_MADR: begin
          r_name  <= {"MADR", 8'h30 + {6'd0, w_s1_k}};
          r_value <= w_watch_k;
        end
        K_MDAT: begin
          r_name  <= {"MDAT", 8'h30 + {6'd0, w_s1_k}};
          r_value <= mem_data;
        end
        K_RF: begin
          r_name  <= {"REG", hex_char({3'b000, w_s1_idx[4]}), hex_char(w_s1_idx[3:0])};
          r_value <= rf_data;
        end
`ifdef DISPLAY_STEP_COUNT_EN
        K_STEPS: begin
          r_name  <= "STEPS";
          r_value <= DATA_W'(r_steps);
        end
`endif
        default: begin
          r_valid <= 1'b0;
          r_name  <= '0;
          r_value <= '0;
        end
      endcase
    end
  end

  assign display_valid = r_valid;
  assign display_name  = r_name;
  assign display_value = r_value;

  logic        r_sync1;
  logic        r_sync2;
  logic [15:0] r_db_cnt;
  logic        r_db_level;
  logic        r_db_prev;
  logic [15:0] r_div;
  logic        r_mode_prev;
  logic        r_cpu_clk;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_db_cnt    <= '0;
      r_db_level  <= 1'b0;
      r_db_prev   <= 1'b0;
      r_div       <= '0;
      r_mode_prev <= run_mode;
      r_cpu_clk   <= 1'b0;
    end else begin
      r_sync1     <= btn_clk;
      r_sync2     <= r_sync1;
      r_db_prev   <= r_db_level;
      r_mode_prev <= run_mode;
      if (r_sync2 != r_db_level) begin
        if (r_db_cnt == DEBOUNCE - 16'd1) begin
          r_db_level <= r_sync2;
          r_db_cnt   <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + 16'd1;
        end
      end else begin
        r_db_cnt <= '0;
      end
      // A mode change only restarts the divider; cpu_clk waits for the next real event.
      if (run_mode != r_mode_prev) begin
        r_div <= '0;
      end else if (run_mode) begin
        if (r_div == RUN_DIV - 16'd1) begin
          r_div     <= '0;
          r_cpu_clk <= ~r_cpu_clk;
        end else begin
          r_div <= r_div + 16'd1;
        end
      end else begin
        r_div <= '0;
        if (r_db_level != r_db_prev) r_cpu_clk <= r_db_level;
      end
    end
  end

  assign cpu_clk = r_cpu_clk;

`ifdef DISPLAY_STEP_COUNT_EN
  logic r_cpu_clk_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cpu_clk_prev <= 1'b0;
      r_steps        <= '0;
    end else begin
      r_cpu_clk_prev <= r_cpu_clk;
      if (r_cpu_clk && !r_cpu_clk_prev && r_steps != 32'hFFFF_FFFF) r_steps <= r_steps + 32'd1;
    end
  end
`else
  assign r_steps = '0;
`endif

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - self-checking bench for display_scan_ctrl
module tb_display_scan_ctrl;

  localparam int          MW         = 2;
  localparam int          RFN        = 32;
  localparam int          B          = 3 + 2 * MW;
  localparam int          STEPS_SLOT = B + RFN;
  localparam logic [15:0] DEB        = 16'd4;
  localparam int          RDIV       = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        btn_clk = 1'b0;
  logic        run_mode = 1'b0;
  logic        cpu_clk;
  logic [31:0] cpu_pc = '0;
  logic [31:0] cpu_inst = '0;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic [5:0]  display_number = '0;
  logic        input_valid = 1'b0;
  logic [31:0] input_value = '0;
  logic        display_valid;
  logic [39:0] display_name;
  logic [31:0] display_value;

  display_scan_ctrl #(
    .DATA_W(32), .RF_NUM(RFN), .MEM_WATCH(MW), .DEBOUNCE(DEB), .RUN_DIV(16'(RDIV))
  ) dut (
    .clk(clk), .reset(reset), .btn_clk(btn_clk), .run_mode(run_mode), .cpu_clk(cpu_clk),
    .cpu_pc(cpu_pc), .cpu_inst(cpu_inst), .rf_addr(rf_addr), .rf_data(rf_data),
    .mem_addr(mem_addr), .mem_data(mem_data), .display_number(display_number),
    .input_valid(input_valid), .input_value(input_value), .display_valid(display_valid),
    .display_name(display_name), .display_value(display_value)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rf_fn(input logic [4:0] a);
    return 32'h5A5A_0000 | {27'd0, a} | ({27'd0, a} << 8);
  endfunction

  function automatic logic [31:0] mem_fn(input logic [31:0] x);
    return {x[15:0], x[31:16]} ^ 32'hC3C3_3C3C;
  endfunction

  assign rf_data  = rf_fn(rf_addr);
  assign mem_data = mem_fn(mem_addr);

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rises = 0;
  logic prev_cpu = 1'b0;
  int   tog_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (cpu_clk !== prev_cpu) begin
      tog_q.push_back(cyc);
      if (cpu_clk === 1'b1) rises++;
    end
    prev_cpu = cpu_clk;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: slot classes straight from the slot map.
  logic [31:0] m_watch [4];
  logic [31:0] m_steps;

  function automatic void slot_info(input int s, output int kd, output int k);
    kd = 0;
    k  = 0;
    if (s < 1 || s > 44) return;
    if (s == 1) kd = 1;
    else if (s == 2) kd = 2;
    else if (s < B) begin
      kd = ((s - 3) % 2 == 0) ? 3 : 4;
      k  = (s - 3) / 2;
    end else if (s < B + RFN) begin
      kd = 5;
      k  = s - B;
    end
`ifdef DISPLAY_STEP_COUNT_EN
    else if (s == STEPS_SLOT) kd = 6;
`endif
  endfunction

  function automatic logic [7:0] hexc(input int d);
    if (d < 10) return 8'(32'h30 + d);
    return 8'(32'h41 + d - 10);
  endfunction

  function automatic logic [39:0] name_of(input int kd, input int k);
    case (kd)
      1: return "   PC";
      2: return " INST";
      3: return {"MADR", 8'(48 + k)};
      4: return {"MDAT", 8'(48 + k)};
      5: return {"REG", hexc(k / 16), hexc(k % 16)};
      6: return "STEPS";
      default: return '0;
    endcase
  endfunction

  function automatic logic [31:0] value_of(input int kd, input int k);
    case (kd)
      1: return cpu_pc;
      2: return cpu_inst;
      3: return m_watch[k];
      4: return mem_fn(m_watch[k]);
      5: return rf_fn(5'(k));
      6: return m_steps;
      default: return '0;
    endcase
  endfunction

  typedef struct {
    logic [5:0]  dn;
    logic        ev;
    logic [39:0] en;
    logic [31:0] evl;
  } vec_t;

  vec_t vt[14];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   t0, d, kd, kk, kd2, kk2, wk;
    logic e_valid;
    logic [39:0] e_name;
    logic [31:0] e_val, e_mem;
    logic [4:0]  m_rf;
    logic [5:0]  m_s1;

    cpu_pc   = 32'hBFC0_0000;
    cpu_inst = 32'h3C1D_0000;
    vt[0]  = '{6'd1,  1'b1, "   PC", 32'hBFC0_0000};
    vt[1]  = '{6'd2,  1'b1, " INST", 32'h3C1D_0000};
    vt[2]  = '{6'd3,  1'b1, "MADR0", 32'h0};
    vt[3]  = '{6'd4,  1'b1, "MDAT0", mem_fn(32'h0)};
    vt[4]  = '{6'd5,  1'b1, "MADR1", 32'h0};
    vt[5]  = '{6'd6,  1'b1, "MDAT1", mem_fn(32'h0)};
    vt[6]  = '{6'd7,  1'b1, "REG00", rf_fn(5'd0)};
    vt[7]  = '{6'd38, 1'b1, "REG1F", rf_fn(5'd31)};
    vt[8]  = '{6'd17, 1'b1, "REG0A", rf_fn(5'd10)};
    vt[9]  = '{6'd0,  1'b0, 40'h0, 32'h0};
    vt[10] = '{6'd40, 1'b0, 40'h0, 32'h0};
    vt[11] = '{6'd44, 1'b0, 40'h0, 32'h0};
    vt[12] = '{6'd45, 1'b0, 40'h0, 32'h0};
    vt[13] = '{6'd63, 1'b0, 40'h0, 32'h0};

    // Reset state and first-output latency.
    reset = 1'b1;
    display_number = 6'd1;
    tick();
    tick();
    chk("rst_valid", display_valid, 1'b0);
    chk("rst_name", display_name, 40'h0);
    chk("rst_value", display_value, 32'h0);
    chk("rst_rf_addr", rf_addr, 5'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_cpu_clk", cpu_clk, 1'b0);
    reset = 1'b0;
    tick();
    chk("lat_cycle1_valid", display_valid, 1'b0);
    tick();
    chk("lat_cycle2_valid", display_valid, 1'b1);
    chk("lat_pc_name", display_name, "   PC");
    chk("lat_pc_value", display_value, 32'hBFC0_0000);

    for (int i = 0; i < 14; i++) begin
      display_number = vt[i].dn;
      tick();
      tick();
      chk($sformatf("vec%0d_valid", i), display_valid, vt[i].ev);
      if (vt[i].ev) begin
        chk($sformatf("vec%0d_name", i), display_name, vt[i].en);
        chk($sformatf("vec%0d_value", i), display_value, vt[i].evl);
      end
    end

    display_number = 6'd38;
    tick();
    chk("reg31_rf_addr", rf_addr, 5'd31);
    tick();
    chk("reg31_name", display_name, "REG1F");
    chk("reg31_value", display_value, rf_fn(5'd31));
    display_number = 6'd0;
    tick();
    tick();
    chk("slot0_invalid", display_valid, 1'b0);
    chk("rf_addr_hold", rf_addr, 5'd31);
    chk("mem_addr_park", mem_addr, 32'h0);

    // Watch address writes.
    display_number = 6'd5;
    tick();
    tick();
    input_value = 32'h10;
    input_valid = 1'b1;
    tick();
    input_valid = 1'b0;
    tick();
    tick();
    chk("madr1_written", display_value, 32'h10);
    display_number = 6'd6;
    tick();
    chk("mdat1_mem_addr", mem_addr, 32'h10);
    tick();
    chk("mdat1_value", display_value, mem_fn(32'h10));
    display_number = 6'd3;
    tick();
    tick();
    chk("madr0_unchanged", display_value, 32'h0);
    display_number = 6'd1;
    tick();
    tick();
    input_value = 32'h20;
    input_valid = 1'b1;
    tick();
    input_valid = 1'b0;
    display_number = 6'd3;
    tick();
    tick();
    chk("default_write_madr0", display_value, 32'h20);
    display_number = 6'd5;
    tick();
    tick();
    chk("madr1_kept", display_value, 32'h10);

    // Reset in the middle of a press aborts it.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rises = 0;
    btn_clk = 1'b1;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    btn_clk = 1'b0;
    repeat (10) tick();
    chk("midpress_reset_no_edge", rises, 0);

    // Bounce then a real press.
    repeat (3) begin
      btn_clk = 1'b1;
      repeat (3) tick();
      btn_clk = 1'b0;
      repeat (2) tick();
    end
    repeat (6) tick();
    chk("bounce_no_edge", rises, 0);
    btn_clk = 1'b1;
    repeat (10) tick();
    btn_clk = 1'b0;
    repeat (12) tick();
    chk("press_one_edge", rises, 1);
    chk("press_released", cpu_clk, 1'b0);
    display_number = 6'(STEPS_SLOT);
    tick();
    tick();
`ifdef DISPLAY_STEP_COUNT_EN
    chk("steps_valid", display_valid, 1'b1);
    chk("steps_name", display_name, "STEPS");
    chk("steps_value", display_value, 32'd1);
`else
    chk("steps_slot_absent", display_valid, 1'b0);
`endif

    // Run mode divider.
    run_mode = 1'b1;
    tog_q.delete();
    t0 = cyc;
    repeat (30) tick();
    chk("run_toggle_count", (tog_q.size() >= 8), 1'b1);
    if (tog_q.size() > 0) begin
      d = tog_q[0] - t0;
      chk("run_first_toggle", (d >= RDIV && d <= RDIV + 1), 1'b1);
    end
    for (int i = 1; i < tog_q.size(); i++) chk("run_half_period", tog_q[i] - tog_q[i-1], RDIV);

    for (int i = 0; i < 20 && cpu_clk !== 1'b1; i++) tick();
    tick();
    reset = 1'b1;
    tick();
    chk("run_reset_cpu_clk", cpu_clk, 1'b0);
    reset = 1'b0;
    tog_q.delete();
    t0 = cyc;
    repeat (8) tick();
    chk("run_restart_count", (tog_q.size() >= 2), 1'b1);
    if (tog_q.size() >= 2) begin
      chk("run_restart_first", tog_q[0] - t0, RDIV);
      chk("run_restart_period", tog_q[1] - tog_q[0], RDIV);
    end

    for (int i = 0; i < 20 && cpu_clk !== 1'b1; i++) tick();
    run_mode = 1'b0;
    tog_q.delete();
    repeat (12) tick();
    chk("mode_switch_hold_edges", tog_q.size(), 0);
    chk("mode_switch_hold_level", cpu_clk, 1'b1);

    // Randomised display traffic against the model.
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    m_s1 = '0;
    m_rf = '0;
    m_steps = '0;
    for (int i = 0; i < 4; i++) m_watch[i] = '0;
    for (int c = 0; c < 300; c++) begin
      display_number = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(45, 63))
                                                   : 6'($urandom_range(0, 44));
      input_valid = ($urandom_range(0, 3) == 0);
      input_value = $urandom;
      cpu_pc      = $urandom;
      cpu_inst    = $urandom;
      slot_info(int'(m_s1), kd, kk);
      e_valid = (kd != 0);
      e_name  = name_of(kd, kk);
      e_val   = value_of(kd, kk);
      if (input_valid) begin
        wk = (kd == 3 || kd == 4) ? kk : 0;
        m_watch[wk] = input_value;
      end
      m_s1 = display_number;
      slot_info(int'(m_s1), kd2, kk2);
      if (kd2 == 5) m_rf = 5'(kk2);
      e_mem = (kd2 == 4) ? m_watch[kk2] : m_watch[0];
      tick();
      chk("rnd_valid", display_valid, e_valid);
      if (e_valid) begin
        chk("rnd_name", display_name, e_name);
        chk("rnd_value", display_value, e_val);
      end
      chk("rnd_rf_addr", rf_addr, m_rf);
      chk("rnd_mem_addr", mem_addr, e_mem);
    end
    input_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_W, 32, width of displayed values and watch addresses.
- RF_NUM, 32, number of register-file entries shown, 1..32.
- MEM_WATCH, 2, number of independent memory watch addresses, 1..4.
- DEBOUNCE, 16'd50000, number of clk cycles btn_clk must stay stable before it is accepted.
- RUN_DIV, 16'd5000, number of clk cycles per cpu_clk half-period in run mode, >=1.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, the single clock.
- reset, in, 1, synchronous, active-high.
- btn_clk, in, 1, raw single-step pushbutton.
- run_mode, in, 1, 1 = free-run, 0 = single-step.
- cpu_clk, out, 1, clock to CPU.
- cpu_pc, in, DATA_W, CPU PC.
- cpu_inst, in, DATA_W, current instruction.
- rf_addr, out, 5, register-file debug read address.
- rf_data, in, DATA_W, combinational RF read data.
- mem_addr, out, DATA_W, watch address being read.
- mem_data, in, DATA_W, combinational memory read data.
- display_number, in, 6, LCD slot being requested, 1..44.
- input_valid, in, 1, one-cycle touch input strobe.
- input_value, in, DATA_W, touch input value.
- display_valid, out, 1, slot content valid.
- display_name, out, 40, 5 ASCII characters.
- display_value, out, DATA_W, slot value.

Function
REQ-003 Slot map SHALL be:
- Slot 1: "   PC" / cpu_pc.
- Slot 2: " INST" / cpu_inst.
- Slot 3+2k: "MADRk" / watch address k.
- Slot 4+2k: "MDATk" / mem_data at watch address k, for k = 0..MEM_WATCH-1.
- Slots B..B+RF_NUM-1, with B = 3+2*MEM_WATCH: "REG" plus two uppercase hex digits of the register index.
- Every other slot: display_valid = 0.

REQ-004 Slot 0 and slots above 44 SHALL produce display_valid = 0.

REQ-005 The display path SHALL be a 2-stage pipeline.
- Stage 1 registers display_number and drives rf_addr and mem_addr from that registered number.
- Stage 2 registers display_valid, display_name and display_value.
- Latency from display_number to outputs SHALL be exactly 2 clk cycles.
- A new display_number is accepted every cycle.

REQ-006 Hex digit encoding SHALL be: 0-9 -> 8'h30+d, A-F -> 8'h41+(d-10).

REQ-007 rf_addr SHALL hold its last value, and mem_addr SHALL show watch address 0, while the stage-1 slot is not an RF or MDAT slot.

REQ-008 On input_valid, the value SHALL be written to the watch address selected as follows:
- If the stage-1 slot is MADRk or MDATk, write input_value to watch address k.
- Otherwise, write to watch address 0.
- The write is visible on display_value 2 cycles after the write cycle, or 3 cycles when the slot is held.

REQ-009 btn_clk SHALL pass through a 2-flop synchroniser followed by a debounce counter.
- The debounced level changes only after the synchronised input differs from it for DEBOUNCE consecutive cycles.
- Any glitch restarts the count.

REQ-010 Single-step mode: cpu_clk SHALL equal the debounced level, registered, giving one cpu_clk rising edge per accepted press.

REQ-011 Run mode: cpu_clk SHALL toggle every RUN_DIV cycles from a 16-bit counter.

REQ-012 Switching run_mode SHALL reset the divider counter.

REQ-013 After a mode switch, cpu_clk SHALL keep its level until the next accepted event, so no runt pulse occurs.

REQ-014 All state machines and counters SHALL be synchronous to clk.

Reset
REQ-015 When reset = 1 on a clk edge, the following SHALL be cleared:
- cpu_clk = 0, display_valid = 0, display_name = 0, display_value = 0.
- rf_addr = 0 and mem_addr = 0.
- All watch addresses = 0.
- Debounce counter, debounced level, synchroniser and divider = 0.

REQ-016 Reset asserted mid-press or mid-divide SHALL abort the operation with no cpu_clk pulse.

REQ-017 After reset deasserts, the first valid display output SHALL appear 2 cycles after the first display_number is sampled.

Configuration
REQ-018 The macro DISPLAY_STEP_COUNT_EN SHALL control the step counter.
- Defined: a 32-bit counter of cpu_clk rising edges (clk-domain detect) is added.
- The counter saturates at 32'hFFFFFFFF and is cleared by reset.
- It is displayed at slot B+RF_NUM as "STEPS".
- Not defined: the counter and the slot are absent, and that slot has display_valid = 0.

Verification
REQ-019 The bench SHALL cover these scenarios (defaults, DEBOUNCE = 4 in sim):
- Reset, then display_number = 1 with cpu_pc = 32'hBFC00000 -> 2 cycles later display_valid = 1, name "   PC", value 32'hBFC00000.
- display_number = 7+31 = 38 -> rf_addr = 31 one cycle later; name "REG1F" and value = rf_data two cycles later; display_number = 0 -> display_valid = 0.
- display_number = 5 (MADR1), input_valid with input_value = 32'h00000010 -> watch address 1 = 32'h10; slot 6 shows mem_data addressed at 32'h10; watch address 0 unchanged.
- btn_clk bounce of 3-cycle pulses, then a held press of 10 cycles -> exactly one cpu_clk rising edge; with DISPLAY_STEP_COUNT_EN, "STEPS" at slot 39 = 1.
- run_mode = 1 with RUN_DIV = 3 -> cpu_clk period 6 cycles; reset asserted mid-period -> cpu_clk = 0 next cycle and the counter restarts.
